// File: rtl/fft_sequencer.sv
// Control sequencer for the 32-point FFT core: captures an SPI frame, loads it into the core,
// starts it, waits for done and unloads the results. Optional WAIT watchdog: FFT_SEQ_TIMEOUT_EN.
module fft_sequencer #(
    parameter int N       = 32,
    parameter int AW      = 6,
    parameter int TIMEOUT = 4096
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            frame_ready,
    input  logic [32*N-1:0] frame_in,
    output logic            frame_ack,
    output logic            fft_reset,
    output logic            fft_load,
    output logic            fft_start,
    output logic [AW-1:0]   fft_adr,
    output logic [31:0]     fft_din,
    input  logic            fft_done,
    input  logic [31:0]     fft_dout,
    output logic [32*N-1:0] result,
    output logic            result_valid,
    input  logic            result_ack,
    output logic            busy,
    output logic            error
);

    localparam int IW = $clog2(N);
    localparam logic [AW:0]   K_LAST_LOAD = (AW+1)'(N - 1);
    localparam logic [AW:0]   K_LAST_UNLD = (AW+1)'(N);
    localparam logic [AW-1:0] ADR_LAST    = AW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_LOAD,
        S_START,
        S_WAIT,
        S_UNLOAD,
        S_HOLD
    } state_t;

    state_t      state_reg;
    logic [AW:0] k_reg;
    logic [31:0] capture_word [N];

    // Elaboration-time guard against an address bus too narrow for the frame.
    if (((2 ** AW) < N) || (TIMEOUT < 1)) begin : g_bad_params
        $error("fft_sequencer: need 2**AW >= N and TIMEOUT >= 1");
    end

`ifdef FFT_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LIMIT = TW'(TIMEOUT);

    logic [TW-1:0] tcnt_reg;
    logic          retry_reg;
    logic          error_reg;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            k_reg     <= '0;
`ifdef FFT_SEQ_TIMEOUT_EN
            tcnt_reg  <= '0;
            retry_reg <= 1'b0;
            error_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (frame_ready) begin
                        state_reg <= S_RST;
                    end
                end
                S_RST: begin
                    k_reg     <= '0;
                    state_reg <= S_LOAD;
`ifdef FFT_SEQ_TIMEOUT_EN
                    retry_reg <= 1'b0;
`endif
                end
                S_LOAD: begin
                    if (k_reg == K_LAST_LOAD) begin
                        k_reg     <= '0;
                        state_reg <= S_START;
                    end else begin
                        k_reg <= k_reg + 1'b1;
                    end
                end
                S_START: begin
                    state_reg <= S_WAIT;
`ifdef FFT_SEQ_TIMEOUT_EN
                    tcnt_reg  <= '0;
`endif
                end
                S_WAIT: begin
                    if (fft_done) begin
                        k_reg     <= '0;
                        state_reg <= S_UNLOAD;
                    end
`ifdef FFT_SEQ_TIMEOUT_EN
                    // A stuck core is retried from the captured frame without a new frame_ack.
                    else if (tcnt_reg == T_LIMIT) begin
                        error_reg <= 1'b1;
                        retry_reg <= 1'b1;
                        state_reg <= S_RST;
                    end else begin
                        tcnt_reg <= tcnt_reg + 1'b1;
                    end
`endif
                end
                S_UNLOAD: begin
                    if (k_reg == K_LAST_UNLD) begin
                        k_reg     <= '0;
                        state_reg <= S_HOLD;
                    end else begin
                        k_reg <= k_reg + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (result_ack) begin
                        state_reg <= S_IDLE;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    k_reg     <= '0;
                end
            endcase
        end
    end

    // Per-word capture and result storage; read data lags the address by one cycle,
    // so slot gi is written while k = gi+1.
    for (genvar gi = 0; gi < N; gi++) begin : g_word
        localparam logic [AW:0] SLOT = (AW+1)'(gi + 1);

        logic [31:0] cap_word_reg;
        logic [31:0] res_word_reg;

        always_ff @(posedge clk) begin
            if (reset) begin
                cap_word_reg <= '0;
                res_word_reg <= '0;
            end else begin
                if ((state_reg == S_IDLE) && frame_ready) begin
                    cap_word_reg <= frame_in[32*gi +: 32];
                end
                if ((state_reg == S_UNLOAD) && (k_reg == SLOT)) begin
                    res_word_reg <= fft_dout;
                end
            end
        end

        assign capture_word[gi]     = cap_word_reg;
        assign result[32*gi +: 32]  = res_word_reg;
    end

    assign busy         = (state_reg != S_IDLE);
    assign fft_reset    = (state_reg == S_RST);
    assign fft_load     = (state_reg == S_LOAD);
    assign fft_start    = (state_reg == S_START);
    assign result_valid = (state_reg == S_HOLD);
    assign fft_din      = fft_load ? capture_word[k_reg[IW-1:0]] : 32'd0;

    always_comb begin
        fft_adr = '0;
        if ((state_reg == S_LOAD) || (state_reg == S_UNLOAD)) begin
            fft_adr = (k_reg == K_LAST_UNLD) ? ADR_LAST : k_reg[AW-1:0];
        end
    end

`ifdef FFT_SEQ_TIMEOUT_EN
    assign frame_ack = (state_reg == S_RST) && !retry_reg;
    assign error     = error_reg;
`else
    assign frame_ack = (state_reg == S_RST);
    assign error     = 1'b0;
`endif

endmodule
